// File: rtl/proc_pkg.sv
// Shared types and defaults for the single-cycle core's run control.
package proc_pkg;

   typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} run_state_t;
   typedef enum logic {OWN_HOST, OWN_CORE} mem_owner_t;

   localparam int unsigned HALT_PC_DEF = 128;

endpackage

// File: rtl/run_sequencer_mem_port_mux.sv
// Combinational dat_mem port mux between host and core; core writes gated by core_en.
module mem_port_mux
   import proc_pkg::*;
#(
   parameter int unsigned AW = 8
) (
   input  mem_owner_t    owner_i,
   input  logic          core_en_i,
   input  logic          host_we_i,
   input  logic [AW-1:0] host_addr_i,
   input  logic [7:0]    host_din_i,
   input  logic          core_we_i,
   input  logic [AW-1:0] core_addr_i,
   input  logic [7:0]    core_din_i,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [7:0]    mem_din_o
);

   always_comb begin
      if (owner_i == OWN_CORE) begin
         mem_we_o   = core_we_i & core_en_i;
         mem_addr_o = core_addr_i;
         mem_din_o  = core_din_i;
      end else begin
         mem_we_o   = host_we_i;
         mem_addr_o = host_addr_i;
         mem_din_o  = host_din_i;
      end
   end

endmodule

// File: rtl/run_sequencer.sv
// Sequences one program run: start pulse, core reset/enable, halt/timeout detection and
// dat_mem port ownership.
module run_sequencer
   import proc_pkg::*;
#(
   parameter int unsigned D       = 12,
   parameter int unsigned AW      = 8,
   parameter int unsigned CW      = 16,
   parameter int unsigned HALT_PC = HALT_PC_DEF,
   parameter int unsigned MAX_CYC = 60000
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          req_i,
   input  logic          host_we_i,
   input  logic [AW-1:0] host_addr_i,
   input  logic [7:0]    host_din_i,
   input  logic          core_we_i,
   input  logic [AW-1:0] core_addr_i,
   input  logic [7:0]    core_din_i,
   input  logic [D-1:0]  prog_ctr_i,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [7:0]    mem_din_o,
   output logic          core_rst_o,
   output logic          core_en_o,
   output logic          busy_o,
   output logic          done_o,
   output logic          timeout_o,
   output logic          host_err_o,
   output logic [CW-1:0] cycle_cnt_o
);

   if (64'(MAX_CYC) >= (64'd1 << CW)) begin : gen_max_cyc_check
      $error("MAX_CYC must be below 2**CW so cycle_cnt cannot wrap");
   end

   run_state_t    state_q, state_d;
   mem_owner_t    owner_q, owner_d;
   logic          req_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          timeout_q, timeout_d;
   logic          core_rst_q, core_rst_d;
   logic          core_en_q, core_en_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          host_err_q, host_err_d;
   logic          start;
   logic          halt;

   assign start = req_i & ~req_q;
   assign halt  = (prog_ctr_i == D'(HALT_PC));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_INIT;
               cnt_d     = '0;
               timeout_d = 1'b0;
            end
         end
         S_INIT: begin
            state_d   = S_RUN;
            cnt_d     = '0;
            timeout_d = 1'b0;
         end
         S_RUN: begin
            cnt_d = cnt_q + CW'(1);
            // Halt takes priority over a coincident timeout.
            if (halt) begin
               state_d   = S_DONE;
               timeout_d = 1'b0;
            end else if (cnt_q == CW'(MAX_CYC - 1)) begin
               state_d   = S_DONE;
               timeout_d = 1'b1;
            end
         end
         S_DONE: begin
            if (!req_i) begin
               state_d   = S_IDLE;
               timeout_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control outputs are registered alongside the state they describe.
   always_comb begin
      core_rst_d = (state_d == S_IDLE) || (state_d == S_INIT);
      core_en_d  = (state_d == S_RUN);
      busy_d     = (state_d == S_INIT) || (state_d == S_RUN);
      done_d     = (state_d == S_DONE);
      owner_d    = busy_d ? OWN_CORE : OWN_HOST;
      host_err_d = host_we_i && (owner_q == OWN_CORE);
   end

   // req_q resets high so a req already asserted at reset release cannot start a run.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         owner_q    <= OWN_HOST;
         req_q      <= 1'b1;
         cnt_q      <= '0;
         timeout_q  <= 1'b0;
         core_rst_q <= 1'b1;
         core_en_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         host_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         req_q      <= req_i;
         cnt_q      <= cnt_d;
         timeout_q  <= timeout_d;
         core_rst_q <= core_rst_d;
         core_en_q  <= core_en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         host_err_q <= host_err_d;
      end
   end

   assign core_rst_o  = core_rst_q;
   assign core_en_o   = core_en_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign timeout_o   = timeout_q;
   assign host_err_o  = host_err_q;
   assign cycle_cnt_o = cnt_q;

   mem_port_mux #(
      .AW(AW)
   ) u_mem_port_mux (
      .owner_i    (owner_q),
      .core_en_i  (core_en_q),
      .host_we_i  (host_we_i),
      .host_addr_i(host_addr_i),
      .host_din_i (host_din_i),
      .core_we_i  (core_we_i),
      .core_addr_i(core_addr_i),
      .core_din_i (core_din_i),
      .mem_we_o   (mem_we_o),
      .mem_addr_o (mem_addr_o),
      .mem_din_o  (mem_din_o)
   );

endmodule
